fifth_loader: RTL and testbench
===============================

# fifth_loader

Boot loader and code-memory front end for the `fifth` core. It owns the 8K×16 instruction RAM and serves the core's `code_addr`/`instruction` fetch port. At power-up it holds the core in reset and accepts a framed program image over a byte stream. It writes the image into code RAM, checks it, and then releases the core; a new frame at any time reloads the RAM.

## Interface
Parameters:
- `SYNC_BYTE`, default 8'hA5: frame start marker.
- `TIMEOUT`, default 1_000_000: maximum idle cycles between bytes inside a frame.
- `TO_W`, default 20: timeout counter width, must hold `TIMEOUT`.

Ports:
- `clk`, in, 1: single clock; all logic on its rising edge.
- `reset`, in, 1: synchronous, active-high.
- `rx_data`, in, 8: stream byte.
- `rx_valid`, in, 1: `rx_data` is valid.
- `rx_ready`, out, 1: byte accepted when `rx_valid && rx_ready`.
- `code_addr`, in, 13: core fetch address (driven from the core's `pc_next`).
- `instruction`, out, 16: RAM word at the `code_addr` sampled on the previous edge.
- `cpu_reset_n`, out, 1: active-low hold to the core's `reset`.
- `load_done`, out, 1: last frame loaded and checksum good.
- `load_error`, out, 1: last frame aborted (bad length, bad checksum, or timeout).
- `words_loaded`, out, 14: data words written in the current or last frame.

## Operation
- Frame format: `SYNC_BYTE`, `LEN_LO`, `LEN_HI`, then LEN words as little-endian byte pairs, then `CSUM`.
- Word k is written to code RAM address k, for k = 0 to LEN−1.
- Checksum rule: the 8-bit sum of `LEN_LO`, `LEN_HI`, every data byte and `CSUM` must be 8'h00 (mod 256). `SYNC_BYTE` is excluded from the sum.
- `rx_ready` is 1 in every state; it is 0 only while `reset` is high.
- States:
  - IDLE: a `SYNC_BYTE` moves to LEN_LO; any other byte is discarded.
  - LEN_LO to LEN_HI. On `LEN_HI`: LEN > 8192 goes to ERR; LEN = 0 goes to CHECK; otherwise goes to DATA_LO.
  - DATA_LO latches the low byte. DATA_HI writes `{hi,lo}` at the word counter, then increments the counter. After word LEN−1 the next state is CHECK; otherwise DATA_LO.
  - CHECK: on the `CSUM` byte, a zero sum goes to RUN, otherwise to ERR.
  - RUN: `cpu_reset_n` = 1. A `SYNC_BYTE` goes to LEN_LO and drops `cpu_reset_n` to 0 on the next edge. Other bytes are discarded.
  - ERR: `load_error` = 1 and the core is held. A `SYNC_BYTE` goes to LEN_LO; other bytes are discarded.
- On entry to LEN_LO: clear `load_done`, `load_error`, `words_loaded` and the checksum accumulator; `cpu_reset_n` = 0.
- Timeout: in LEN_LO through CHECK, the idle counter counts cycles with no accepted byte and clears on each accepted byte. When it reaches `TIMEOUT`, the state goes to ERR.
- RAM contents written before an abort persist; the core is not released over a partial image.
- Reset mid-frame: returns to IDLE with the counters cleared. RAM contents are not cleared.

## Timing
- Reset values: `cpu_reset_n` = 0, `load_done` = 0, `load_error` = 0, `words_loaded` = 0, `rx_ready` = 0, state IDLE. `instruction` is undefined until the first fetch edge after reset.
- Fetch latency is 1 cycle: `instruction` at cycle n+1 is RAM[`code_addr` @ n]. This matches the core presenting `pc_next` as `code_addr`.
- RAM write commits on the edge that accepts the `DATA_HI` byte. A read of the same address on that edge returns the old data; the core is held in that case anyway.
- `cpu_reset_n` rises on the edge after the `CSUM` byte is accepted; `load_done` rises on that same edge.
- One byte per cycle is sustained, so the minimum frame time is 4 + 2·LEN cycles.

## Structure
- Shared package `fifth_pkg` holds:
  - the loader state enum;
  - `CODE_AW` = 13 and `CODE_DEPTH` = 8192;
  - `INSN_W` = 16;
  - the `SYNC_BYTE` default.
- Sub-module `fifth_code_ram`: simple dual-port RAM with one write port and one synchronous read port, 8192×16.
- The FSM, counters and checksum logic live in `fifth_loader`.

## Test plan
- Frame A5 03 00 05 80 02 60 00 00 16 -> RAM[0..2] = 8005, 6002, 0000; `cpu_reset_n` rises 1 cycle after the 16 byte; `load_done` = 1; `words_loaded` = 3.
- Same frame with `CSUM` = 17 -> `load_error` = 1, `cpu_reset_n` stays 0; RAM[0..2] still written; a following valid frame recovers.
- Frame A5 01 20 (LEN = 0x2001) -> ERR right after `LEN_HI`; no RAM writes.
- Valid frame stalled for `TIMEOUT` cycles after its 4th data byte -> ERR; `words_loaded` = 2.
- In RUN, send A5 -> `cpu_reset_n` = 0 on the next edge; reload with A5 00 00 00 -> RUN with `words_loaded` = 0.
- After a load, drive `code_addr` 0, 1, 2 on consecutive cycles -> `instruction` shows 8005, 6002, 0000 one cycle later each. Assert `reset` mid-frame -> IDLE with `cpu_reset_n` = 0.

Source files
------------

// File: rtl/fifth_pkg.sv
// Shared definitions for the fifth core's code memory and boot loader.
package fifth_pkg;

  localparam int CODE_AW    = 13;
  localparam int CODE_DEPTH = 8192;
  localparam int INSN_W     = 16;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  typedef enum logic [2:0] {
    LD_IDLE,
    LD_LEN_LO,
    LD_LEN_HI,
    LD_DATA_LO,
    LD_DATA_HI,
    LD_CHECK,
    LD_RUN,
    LD_ERR
  } ld_state_e;

  // States in which a frame is in progress and the idle timeout is armed.
  function automatic logic in_frame(input ld_state_e s);
    return s inside {LD_LEN_LO, LD_LEN_HI, LD_DATA_LO, LD_DATA_HI, LD_CHECK};
  endfunction

endpackage

// File: rtl/fifth_code_ram.sv
// 8K x 16 instruction RAM: one write port, one registered read port.
module fifth_code_ram
  import fifth_pkg::*;
(
  input  logic               clk,
  input  logic               we_i,
  input  logic [CODE_AW-1:0] waddr_i,
  input  logic [INSN_W-1:0]  wdata_i,
  input  logic [CODE_AW-1:0] raddr_i,
  output logic [INSN_W-1:0]  rdata_o
);

  logic [INSN_W-1:0] mem_q [CODE_DEPTH];
  logic [INSN_W-1:0] rdata_q;

  // Read-before-write: a same-address read on a write edge returns old data.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fifth_loader.sv
// Boot loader for the fifth core: receives a framed image over a byte stream,
// writes it into code RAM, verifies the checksum and then releases the core.
module fifth_loader
  import fifth_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
  parameter int         TIMEOUT   = 1_000_000,
  parameter int         TO_W      = 20
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  output logic                rx_ready,
  input  logic [CODE_AW-1:0]  code_addr,
  output logic [INSN_W-1:0]   instruction,
  output logic                cpu_reset_n,
  output logic                load_done,
  output logic                load_error,
  output logic [CODE_AW:0]    words_loaded
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [15:0]     MAX_LEN = 16'(CODE_DEPTH);

  ld_state_e         state_q, state_d;
  logic [CODE_AW:0]  len_q, len_d;
  logic [CODE_AW:0]  words_q, words_d;
  logic [7:0]        lo_q, lo_d;
  logic [7:0]        sum_q, sum_d;
  logic [TO_W-1:0]   idle_q, idle_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              accept;
  logic              ram_we;
  logic [7:0]        sum_add;
  logic [15:0]       pair_word;

  assign rx_ready  = ~reset;
  assign accept    = rx_valid & rx_ready;
  assign sum_add   = sum_q + rx_data;
  // LEN and data words both arrive as {hi, lo} with lo latched one byte earlier.
  assign pair_word = {rx_data, lo_q};

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    words_d = words_q;
    lo_d    = lo_q;
    sum_d   = sum_q;
    idle_d  = '0;
    done_d  = done_q;
    err_d   = err_q;
    ram_we  = 1'b0;

    if (in_frame(state_q)) begin
      idle_d = idle_q + 1'b1;
    end

    if (accept) begin
      idle_d = '0;
      case (state_q)
        LD_IDLE, LD_RUN, LD_ERR: begin
          if (rx_data == SYNC_BYTE) begin
            state_d = LD_LEN_LO;
            done_d  = 1'b0;
            err_d   = 1'b0;
            words_d = '0;
            sum_d   = '0;
          end
        end
        LD_LEN_LO: begin
          lo_d    = rx_data;
          sum_d   = sum_add;
          state_d = LD_LEN_HI;
        end
        LD_LEN_HI: begin
          sum_d = sum_add;
          len_d = pair_word[CODE_AW:0];
          if (pair_word > MAX_LEN) begin
            state_d = LD_ERR;
            err_d   = 1'b1;
          end else if (pair_word == 16'd0) begin
            state_d = LD_CHECK;
          end else begin
            state_d = LD_DATA_LO;
          end
        end
        LD_DATA_LO: begin
          lo_d    = rx_data;
          sum_d   = sum_add;
          state_d = LD_DATA_HI;
        end
        LD_DATA_HI: begin
          ram_we  = 1'b1;
          sum_d   = sum_add;
          words_d = words_q + 1'b1;
          state_d = (words_d == len_q) ? LD_CHECK : LD_DATA_LO;
        end
        LD_CHECK: begin
          if (sum_add == 8'h00) begin
            state_d = LD_RUN;
            done_d  = 1'b1;
          end else begin
            state_d = LD_ERR;
            err_d   = 1'b1;
          end
        end
        default: begin
          state_d = LD_IDLE;
        end
      endcase
    end else if (in_frame(state_q) && idle_q == TO_LAST) begin
      state_d = LD_ERR;
      err_d   = 1'b1;
      idle_d  = '0;
    end
  end

  // Reset clears loader state only; RAM contents survive.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= LD_IDLE;
      len_q   <= '0;
      words_q <= '0;
      lo_q    <= '0;
      sum_q   <= '0;
      idle_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      words_q <= words_d;
      lo_q    <= lo_d;
      sum_q   <= sum_d;
      idle_q  <= idle_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  fifth_code_ram u_code_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (words_q[CODE_AW-1:0]),
    .wdata_i (pair_word),
    .raddr_i (code_addr),
    .rdata_o (instruction)
  );

  assign cpu_reset_n  = (state_q == LD_RUN);
  assign load_done    = done_q;
  assign load_error   = err_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_fifth_loader.sv
// Scoreboard bench for fifth_loader: frame outcomes and fetches are queued by
// the stimulus and checked by a monitor when the DUT presents them.
module tb_fifth_loader;

  localparam int TO = 40;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [12:0] code_addr;
  logic [15:0] instruction;
  logic        cpu_reset_n;
  logic        load_done;
  logic        load_error;
  logic [13:0] words_loaded;

  always #5 clk = ~clk;

  fifth_loader #(
    .SYNC_BYTE (8'hA5),
    .TIMEOUT   (TO),
    .TO_W      (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .code_addr    (code_addr),
    .instruction  (instruction),
    .cpu_reset_n  (cpu_reset_n),
    .load_done    (load_done),
    .load_error   (load_error),
    .words_loaded (words_loaded)
  );

  typedef struct packed {
    logic        done;
    logic        err;
    logic        rstn;
    logic [13:0] words;
  } outcome_t;

  int          checks = 0;
  int          passed = 0;
  outcome_t    out_q[$];
  logic [15:0] insn_q[$];
  logic [7:0]  frm[$];
  logic        fetch_req = 1'b0;
  logic        fetch_vld = 1'b0;
  logic        prev_done = 1'b0;
  logic        prev_err  = 1'b0;
  outcome_t    mon_exp;
  outcome_t    mon_cur;
  logic [15:0] mon_insn;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic outcome_t mk_out(input logic d, input logic e, input logic r,
                                      input logic [13:0] w);
    outcome_t o;
    o.done  = d;
    o.err   = e;
    o.rstn  = r;
    o.words = w;
    return o;
  endfunction

  // Monitor: fetch results one cycle after a request, frame outcomes on the
  // rising edge of load_done or load_error.
  always @(posedge clk) fetch_vld <= fetch_req;

  always @(negedge clk) begin
    if (fetch_vld) begin
      if (insn_q.size() == 0) begin
        checks++;
        $display("FAIL fetch_unexpected: instruction %0h with no expectation queued", instruction);
      end else begin
        mon_insn = insn_q.pop_front();
        chk("instruction", 32'(instruction), 32'(mon_insn));
        $display("fetch: addr-1 result %h expected %h", instruction, mon_insn);
      end
    end
    if (!reset && ((load_done && !prev_done) || (load_error && !prev_err))) begin
      mon_cur = mk_out(load_done, load_error, cpu_reset_n, words_loaded);
      if (out_q.size() == 0) begin
        checks++;
        $display("FAIL outcome_unexpected: status %0h with no expectation queued", mon_cur);
      end else begin
        mon_exp = out_q.pop_front();
        chk("outcome", 32'(mon_cur), 32'(mon_exp));
        $display("outcome: done=%0b err=%0b rstn=%0b words=%0d", load_done, load_error,
                 cpu_reset_n, words_loaded);
      end
    end
    prev_done = load_done;
    prev_err  = load_error;
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  // Sends frm; the core must be held right up to the CSUM edge.
  task automatic load_frame(input logic exp_run);
    for (int i = 0; i < frm.size() - 1; i++) send_byte(frm[i]);
    chk("rstn_before_csum", 32'(cpu_reset_n), 32'(1'b0));
    send_byte(frm[frm.size() - 1]);
    chk("rstn_after_csum", 32'(cpu_reset_n), 32'(exp_run));
  endtask

  task automatic fetch(input logic [12:0] a, input logic [15:0] e);
    @(negedge clk);
    code_addr = a;
    fetch_req = 1'b1;
    insn_q.push_back(e);
    @(posedge clk);
  endtask

  task automatic fetch_end();
    @(negedge clk);
    fetch_req = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    rx_valid  = 1'b0;
    rx_data   = 8'h00;
    code_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rstn",   32'(cpu_reset_n),  32'(1'b0));
    chk("reset_done",   32'(load_done),    32'(1'b0));
    chk("reset_err",    32'(load_error),   32'(1'b0));
    chk("reset_words",  32'(words_loaded), 32'(14'd0));
    chk("reset_ready",  32'(rx_ready),     32'(1'b0));
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("ready_after_reset", 32'(rx_ready), 32'(1'b1));

    // Frame A: three words, good checksum
    out_q.push_back(mk_out(1'b1, 1'b0, 1'b1, 14'd3));
    frm = '{8'hA5, 8'h03, 8'h00, 8'h05, 8'h80, 8'h02, 8'h60, 8'h00, 8'h00, 8'h16};
    load_frame(1'b1);
    fetch(13'd0, 16'h8005);
    fetch(13'd1, 16'h6002);
    fetch(13'd2, 16'h0000);
    fetch_end();

    // Frame B: two different words, RAM[2] untouched
    out_q.push_back(mk_out(1'b1, 1'b0, 1'b1, 14'd2));
    frm = '{8'hA5, 8'h02, 8'h00, 8'h34, 8'h12, 8'hCD, 8'hAB, 8'h40};
    load_frame(1'b1);
    fetch(13'd0, 16'h1234);
    fetch(13'd1, 16'hABCD);
    fetch(13'd2, 16'h0000);
    fetch_end();

    // Frame A with bad checksum: error, but its words still land in RAM
    out_q.push_back(mk_out(1'b0, 1'b1, 1'b0, 14'd3));
    frm = '{8'hA5, 8'h03, 8'h00, 8'h05, 8'h80, 8'h02, 8'h60, 8'h00, 8'h00, 8'h17};
    load_frame(1'b0);
    chk("bad_csum_error", 32'(load_error), 32'(1'b1));
    fetch(13'd0, 16'h8005);
    fetch(13'd1, 16'h6002);
    fetch_end();

    // Recovery with a good frame
    out_q.push_back(mk_out(1'b1, 1'b0, 1'b1, 14'd3));
    frm = '{8'hA5, 8'h03, 8'h00, 8'h05, 8'h80, 8'h02, 8'h60, 8'h00, 8'h00, 8'h16};
    load_frame(1'b1);

    // LEN = 0x2001: error right after LEN_HI, later bytes discarded
    out_q.push_back(mk_out(1'b0, 1'b1, 1'b0, 14'd0));
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h20);
    chk("len_too_big_error", 32'(load_error), 32'(1'b1));
    send_byte(8'h11);
    send_byte(8'h22);
    fetch(13'd0, 16'h8005);
    fetch_end();

    // LEN = 0x2000 is legal; one word in, then reset mid-frame
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h20);
    chk("len_max_no_error", 32'(load_error), 32'(1'b0));
    send_byte(8'h77);
    send_byte(8'h66);
    chk("len_max_words", 32'(words_loaded), 32'(14'd1));
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midreset_rstn",  32'(cpu_reset_n),  32'(1'b0));
    chk("midreset_words", 32'(words_loaded), 32'(14'd0));
    chk("midreset_ready", 32'(rx_ready),     32'(1'b0));
    @(negedge clk);
    reset = 1'b0;
    send_byte(8'h88);
    chk("idle_discard_words", 32'(words_loaded), 32'(14'd0));
    fetch(13'd0, 16'h6677);
    fetch_end();

    // Stall after the fourth data byte until the idle timeout fires
    out_q.push_back(mk_out(1'b0, 1'b1, 1'b0, 14'd2));
    frm = '{8'hA5, 8'h03, 8'h00, 8'h05, 8'h80, 8'h02, 8'h60};
    for (int i = 0; i < frm.size(); i++) send_byte(frm[i]);
    repeat (TO - 2) @(posedge clk);
    #1;
    chk("no_early_timeout", 32'(load_error), 32'(1'b0));
    repeat (4) @(posedge clk);
    #1;
    chk("timeout_error", 32'(load_error),   32'(1'b1));
    chk("timeout_words", 32'(words_loaded), 32'(14'd2));

    // Good load, then a SYNC in RUN re-holds the core; empty frame reruns
    out_q.push_back(mk_out(1'b1, 1'b0, 1'b1, 14'd3));
    frm = '{8'hA5, 8'h03, 8'h00, 8'h05, 8'h80, 8'h02, 8'h60, 8'h00, 8'h00, 8'h16};
    load_frame(1'b1);
    send_byte(8'hA5);
    chk("run_sync_rstn", 32'(cpu_reset_n), 32'(1'b0));
    chk("run_sync_done", 32'(load_done),   32'(1'b0));
    out_q.push_back(mk_out(1'b1, 1'b0, 1'b1, 14'd0));
    frm = '{8'h00, 8'h00, 8'h00};
    load_frame(1'b1);
    fetch(13'd0, 16'h8005);
    fetch(13'd1, 16'h6002);
    fetch(13'd2, 16'h0000);
    fetch_end();

    for (int i = 0; i < 20 && (out_q.size() != 0 || insn_q.size() != 0); i++)
      @(posedge clk);
    @(negedge clk);
    if (out_q.size() != 0 || insn_q.size() != 0) begin
      checks++;
      $display("FAIL drain: %0d outcomes and %0d fetches still pending, required 0",
               out_q.size(), insn_q.size());
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
